// File: rtl/mips32_pipe_if.sv
// Status interface of the mips32_pipe core. It carries the halt indication
// from the core (master) to the environment (slave).
interface mips32_pipe_if;
    logic halted;

    modport master (output halted);
    modport slave  (input  halted);
endinterface

// File: rtl/mips32_pipe.sv
// Five-stage pipelined MIPS32-subset core with a unified word-addressed memory.
// Forwarding into EX, branch resolution in EX, and a freeze on HLT.
module mips32_pipe (
    input  logic          clk,
    input  logic          rst_n,
    mips32_pipe_if.master o_status
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;
    localparam logic [5:0] OP_NOP   = 6'b010001;

    localparam logic [31:0] NOP_INSTR = {OP_NOP, 26'd0};

    typedef enum logic [2:0] {
        T_NOP, T_RR, T_RI, T_LOAD, T_STORE, T_BRANCH, T_HALT
    } itype_t;

    function automatic itype_t decode(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: decode = T_RR;
            OP_ADDI, OP_SUBI, OP_SLTI:                     decode = T_RI;
            OP_LW:                                         decode = T_LOAD;
            OP_SW:                                         decode = T_STORE;
            OP_BNEQZ, OP_BEQZ:                             decode = T_BRANCH;
            OP_HLT:                                        decode = T_HALT;
            default:                                       decode = T_NOP;
        endcase
    endfunction

    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:1023];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    logic        r_fetch_stop;
    logic [31:0] r_ifid_ir;
    logic [31:0] r_ifid_npc;

    itype_t      r_idex_type;
    logic [5:0]  r_idex_op;
    logic [31:0] r_idex_npc;
    logic [31:0] r_idex_a;
    logic [31:0] r_idex_b;
    logic [31:0] r_idex_imm;
    logic [4:0]  r_idex_rs;
    logic [4:0]  r_idex_rt;
    logic [4:0]  r_idex_dst;
    logic        r_idex_we;

    itype_t      r_exmem_type;
    logic [31:0] r_exmem_alu;
    logic [31:0] r_exmem_b;
    logic [4:0]  r_exmem_dst;
    logic        r_exmem_we;

    logic [31:0] r_memwb_res;
    logic [4:0]  r_memwb_dst;
    logic        r_memwb_we;
    logic        r_memwb_halt;

    logic [31:0] w_if_ir;
    logic        w_fetch_en;
    logic [5:0]  w_id_op;
    logic [4:0]  w_id_rs;
    logic [4:0]  w_id_rt;
    logic [4:0]  w_id_dst;
    itype_t      w_id_type;
    logic [31:0] w_id_a;
    logic [31:0] w_id_b;
    logic [31:0] w_id_imm;
    logic        w_id_we;
    logic        w_id_hlt;
    logic        w_wb_we;
    logic [31:0] w_ex_a;
    logic [31:0] w_ex_b;
    logic [31:0] w_ex_alu;
    logic [31:0] w_ex_target;
    logic        w_ex_taken;
    logic [31:0] w_mem_rdata;

    assign o_status.halted = HALTED;

    assign w_if_ir     = Mem[PC[9:0]];
    assign w_mem_rdata = Mem[r_exmem_alu[9:0]];
    assign w_wb_we     = r_memwb_we && !HALTED;

    assign w_id_op   = r_ifid_ir[31:26];
    assign w_id_rs   = r_ifid_ir[25:21];
    assign w_id_rt   = r_ifid_ir[20:16];
    assign w_id_imm  = {{16{r_ifid_ir[15]}}, r_ifid_ir[15:0]};
    assign w_id_type = decode(w_id_op);
    assign w_id_dst  = (w_id_type == T_RR) ? r_ifid_ir[15:11] : w_id_rt;
    assign w_id_we   = ((w_id_type == T_RR) || (w_id_type == T_RI) || (w_id_type == T_LOAD))
                       && (w_id_dst != 5'd0);
    assign w_id_hlt  = (w_id_type == T_HALT);
    assign w_fetch_en = !r_fetch_stop && !w_id_hlt;

    // Register file read is write-before-read: the WB result bypasses the array.
    always_comb begin
        w_id_a = Reg[w_id_rs];
        w_id_b = Reg[w_id_rt];
        if (w_id_rs == 5'd0)
            w_id_a = '0;
        else if (w_wb_we && (r_memwb_dst == w_id_rs))
            w_id_a = r_memwb_res;
        if (w_id_rt == 5'd0)
            w_id_b = '0;
        else if (w_wb_we && (r_memwb_dst == w_id_rt))
            w_id_b = r_memwb_res;
    end

    // A load in EX/MEM only holds its address, so it never forwards from there.
    always_comb begin
        w_ex_a = r_idex_a;
        w_ex_b = r_idex_b;
        if (r_exmem_we && (r_exmem_type != T_LOAD) && (r_exmem_dst == r_idex_rs))
            w_ex_a = r_exmem_alu;
        else if (r_memwb_we && (r_memwb_dst == r_idex_rs))
            w_ex_a = r_memwb_res;
        if (r_exmem_we && (r_exmem_type != T_LOAD) && (r_exmem_dst == r_idex_rt))
            w_ex_b = r_exmem_alu;
        else if (r_memwb_we && (r_memwb_dst == r_idex_rt))
            w_ex_b = r_memwb_res;
    end

    always_comb begin
        w_ex_alu = w_ex_a + r_idex_imm;
        case (r_idex_op)
            OP_ADD:  w_ex_alu = w_ex_a + w_ex_b;
            OP_SUB:  w_ex_alu = w_ex_a - w_ex_b;
            OP_AND:  w_ex_alu = w_ex_a & w_ex_b;
            OP_OR:   w_ex_alu = w_ex_a | w_ex_b;
            OP_SLT:  w_ex_alu = {31'd0, $signed(w_ex_a) < $signed(w_ex_b)};
            OP_MUL:  w_ex_alu = w_ex_a * w_ex_b;
            OP_ADDI: w_ex_alu = w_ex_a + r_idex_imm;
            OP_SUBI: w_ex_alu = w_ex_a - r_idex_imm;
            OP_SLTI: w_ex_alu = {31'd0, $signed(w_ex_a) < $signed(r_idex_imm)};
            default: w_ex_alu = w_ex_a + r_idex_imm;
        endcase
    end

    assign w_ex_target = r_idex_npc + r_idex_imm;
    assign w_ex_taken  = (r_idex_type == T_BRANCH) &&
                         ((r_idex_op == OP_BEQZ) ? (w_ex_a == 32'd0) : (w_ex_a != 32'd0));

    // A taken branch squashes the IF and ID slots, including an HLT sitting in ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            r_fetch_stop <= 1'b0;
            r_ifid_ir    <= NOP_INSTR;
            r_ifid_npc   <= '0;
            r_idex_type  <= T_NOP;
            r_idex_op    <= OP_NOP;
            r_idex_npc   <= '0;
            r_idex_a     <= '0;
            r_idex_b     <= '0;
            r_idex_imm   <= '0;
            r_idex_rs    <= '0;
            r_idex_rt    <= '0;
            r_idex_dst   <= '0;
            r_idex_we    <= 1'b0;
            r_exmem_type <= T_NOP;
            r_exmem_alu  <= '0;
            r_exmem_b    <= '0;
            r_exmem_dst  <= '0;
            r_exmem_we   <= 1'b0;
            r_memwb_res  <= '0;
            r_memwb_dst  <= '0;
            r_memwb_we   <= 1'b0;
            r_memwb_halt <= 1'b0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= w_ex_taken;
            if (r_memwb_halt)
                HALTED <= 1'b1;

            if (w_ex_taken) begin
                PC        <= w_ex_target;
                r_ifid_ir <= NOP_INSTR;
            end else if (w_fetch_en) begin
                PC         <= PC + 32'd1;
                r_ifid_ir  <= w_if_ir;
                r_ifid_npc <= PC + 32'd1;
            end else begin
                r_ifid_ir <= NOP_INSTR;
            end
            if (w_id_hlt && !w_ex_taken)
                r_fetch_stop <= 1'b1;

            if (w_ex_taken) begin
                r_idex_type <= T_NOP;
                r_idex_op   <= OP_NOP;
                r_idex_we   <= 1'b0;
            end else begin
                r_idex_type <= w_id_type;
                r_idex_op   <= w_id_op;
                r_idex_npc  <= r_ifid_npc;
                r_idex_a    <= w_id_a;
                r_idex_b    <= w_id_b;
                r_idex_imm  <= w_id_imm;
                r_idex_rs   <= w_id_rs;
                r_idex_rt   <= w_id_rt;
                r_idex_dst  <= w_id_dst;
                r_idex_we   <= w_id_we;
            end

            r_exmem_type <= r_idex_type;
            r_exmem_alu  <= w_ex_alu;
            r_exmem_b    <= w_ex_b;
            r_exmem_dst  <= r_idex_dst;
            r_exmem_we   <= r_idex_we;

            r_memwb_res  <= (r_exmem_type == T_LOAD) ? w_mem_rdata : r_exmem_alu;
            r_memwb_dst  <= r_exmem_dst;
            r_memwb_we   <= r_exmem_we;
            r_memwb_halt <= (r_exmem_type == T_HALT);
        end
    end

    // Register file and memory are never reset so that preloaded contents survive.
    always_ff @(posedge clk) begin
        if (rst_n && w_wb_we)
            Reg[r_memwb_dst] <= r_memwb_res;
    end

    always_ff @(posedge clk) begin
        if (rst_n && !HALTED && (r_exmem_type == T_STORE))
            Mem[r_exmem_alu[9:0]] <= r_exmem_b;
    end

endmodule

// File: tb/tb_mips32_pipe.sv
// Directed bench for mips32_pipe: a table of single-instruction ALU vectors,
// then hand-written programs for forwarding, memory, branch, halt and reset.
module tb_mips32_pipe;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_SLT  = 6'b000100;
    localparam logic [5:0] OP_MUL  = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b001001;
    localparam logic [5:0] OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011;
    localparam logic [5:0] OP_SLTI = 6'b001100;
    localparam logic [5:0] OP_BEQZ = 6'b001110;
    localparam logic [5:0] OP_UNDF = 6'b010101;
    localparam logic [31:0] HLT_W  = 32'hfc00_0000;
    localparam logic [31:0] NOP_W  = 32'h4400_0000;

    logic clk = 1'b0;
    logic rst_n;

    mips32_pipe_if ifc ();

    mips32_pipe dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .o_status (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        isImm;
        logic [15:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [0:13];
    logic [31:0] prog [$];
    logic [31:0] regInit [0:31];
    int          nChecks = 0;
    int          nFails  = 0;
    int          haltEdge;
    int          pulses;
    int          pulseEdge;
    int          watchEdge;
    int          watchReg;
    logic [31:0] watchVal;

    function automatic logic [31:0] encR(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task loadProgram;
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.Mem[i] <= 32'd0;
        for (int i = 0; i < prog.size(); i++) dut.Mem[i] <= prog[i];
        for (int r = 0; r < 32; r++) dut.Reg[r] <= regInit[r];
        @(negedge clk);
    endtask

    task runUntilHalt(input int limit);
        haltEdge  = -1;
        pulses    = 0;
        pulseEdge = -1;
        watchEdge = -1;
        for (int e = 0; e < limit && haltEdge < 0; e++) begin
            @(posedge clk);
            #1;
            if (dut.TAKEN_BRANCH) begin
                pulses++;
                if (pulseEdge < 0) pulseEdge = e;
            end
            if (watchEdge < 0 && dut.Reg[watchReg] === watchVal) watchEdge = e;
            if (dut.HALTED) haltEdge = e;
        end
        checkOutput("halted_out", {31'd0, ifc.halted}, 32'd1);
    endtask

    task applyStimulus(input int limit);
        loadProgram();
        rst_n = 1'b1;
        runUntilHalt(limit);
    endtask

    task clearRegs;
        for (int r = 0; r < 32; r++) regInit[r] = 32'd0;
        watchReg = 0;
        watchVal = 32'hffff_ffff;
    endtask

    initial begin
        rst_n = 1'b0;
        vecs[0]  = '{OP_ADD,  1'b0, 16'h0000, 32'd7,         32'd5,         32'd12};
        vecs[1]  = '{OP_ADD,  1'b0, 16'h0000, 32'hffff_ffff, 32'd1,         32'd0};
        vecs[2]  = '{OP_SUB,  1'b0, 16'h0000, 32'd5,         32'd7,         32'hffff_fffe};
        vecs[3]  = '{OP_AND,  1'b0, 16'h0000, 32'hf0f0_f0f0, 32'hff00_ff00, 32'hf000_f000};
        vecs[4]  = '{OP_OR,   1'b0, 16'h0000, 32'hf0f0_f0f0, 32'h0f0f_0000, 32'hffff_f0f0};
        vecs[5]  = '{OP_SLT,  1'b0, 16'h0000, 32'hffff_fffd, 32'd2,         32'd1};
        vecs[6]  = '{OP_SLT,  1'b0, 16'h0000, 32'd2,         32'hffff_fffd, 32'd0};
        vecs[7]  = '{OP_MUL,  1'b0, 16'h0000, 32'd7,         32'd6,         32'd42};
        vecs[8]  = '{OP_MUL,  1'b0, 16'h0000, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000};
        vecs[9]  = '{OP_ADDI, 1'b1, 16'hfffc, 32'd100,       32'd0,         32'd96};
        vecs[10] = '{OP_SUBI, 1'b1, 16'h0003, 32'd10,        32'd0,         32'd7};
        vecs[11] = '{OP_SLTI, 1'b1, 16'hffff, 32'hffff_fff0, 32'd0,         32'd1};
        vecs[12] = '{OP_SLTI, 1'b1, 16'h0003, 32'd5,         32'd0,         32'd0};
        vecs[13] = '{OP_UNDF, 1'b0, 16'h0000, 32'd3,         32'd4,         32'h5a5a_5a5a};

        for (int v = 0; v < 14; v++) begin
            clearRegs();
            regInit[1] = vecs[v].a;
            regInit[2] = vecs[v].b;
            regInit[3] = 32'h5a5a_5a5a;
            prog.delete();
            if (vecs[v].isImm) prog.push_back(encI(vecs[v].op, 5'd1, 5'd3, vecs[v].imm));
            else               prog.push_back(encR(vecs[v].op, 5'd1, 5'd2, 5'd3));
            prog.push_back(HLT_W);
            applyStimulus(20);
            checkOutput($sformatf("vec%0d_r3", v), dut.Reg[3], vecs[v].exp);
        end

        clearRegs();
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        watchReg = 5;
        watchVal = 32'd55;
        applyStimulus(40);
        checkOutput("p1_r1", dut.Reg[1], 32'd10);
        checkOutput("p1_r2", dut.Reg[2], 32'd20);
        checkOutput("p1_r3", dut.Reg[3], 32'd25);
        checkOutput("p1_r4", dut.Reg[4], 32'd30);
        checkOutput("p1_r5", dut.Reg[5], 32'd55);
        checkOutput("p1_pc", dut.PC, 32'd9);
        checkOutput("p1_r5_edge", watchEdge, 32'd11);
        checkOutput("p1_halt_edge", haltEdge, 32'd12);
        checkOutput("p1_no_branch", pulses, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("p1_pc_frozen", dut.PC, 32'd9);

        clearRegs();
        regInit[4] = 32'h1234_5678;
        loadProgram();
        rst_n = 1'b1;
        for (int e = 0; e < 6; e++) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_pc", dut.PC, 32'd0);
        checkOutput("rst_halted", {31'd0, dut.HALTED}, 32'd0);
        checkOutput("rst_halted_out", {31'd0, ifc.halted}, 32'd0);
        checkOutput("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_r4_kept", dut.Reg[4], 32'h1234_5678);
        @(negedge clk);
        rst_n = 1'b1;
        runUntilHalt(40);
        checkOutput("rerun_r1", dut.Reg[1], 32'd10);
        checkOutput("rerun_r4", dut.Reg[4], 32'd30);
        checkOutput("rerun_r5", dut.Reg[5], 32'd55);
        checkOutput("rerun_pc", dut.PC, 32'd9);

        clearRegs();
        prog = '{encI(OP_ADDI, 5'd0, 5'd1, 16'd5), encR(OP_ADD, 5'd1, 5'd1, 5'd2),
                 encR(OP_SUB, 5'd2, 5'd1, 5'd3), HLT_W};
        applyStimulus(30);
        checkOutput("fwd_r2", dut.Reg[2], 32'd10);
        checkOutput("fwd_r3", dut.Reg[3], 32'd5);

        clearRegs();
        prog = '{encI(OP_ADDI, 5'd0, 5'd1, 16'd77), encI(OP_SW, 5'd0, 5'd1, 16'd200),
                 encI(OP_LW, 5'd0, 5'd2, 16'd200), NOP_W, encR(OP_ADD, 5'd2, 5'd2, 5'd3), HLT_W};
        applyStimulus(30);
        checkOutput("mem_200", dut.Mem[200], 32'd77);
        checkOutput("mem_r2", dut.Reg[2], 32'd77);
        checkOutput("mem_r3", dut.Reg[3], 32'd154);
        checkOutput("mem_halt_edge", haltEdge, 32'd9);

        clearRegs();
        prog = '{encI(OP_ADDI, 5'd0, 5'd1, 16'd0), encI(OP_BEQZ, 5'd1, 5'd0, 16'd2),
                 encI(OP_ADDI, 5'd0, 5'd2, 16'd1), encI(OP_ADDI, 5'd0, 5'd3, 16'd1),
                 encI(OP_ADDI, 5'd0, 5'd4, 16'd9), HLT_W};
        applyStimulus(30);
        checkOutput("br_r2", dut.Reg[2], 32'd0);
        checkOutput("br_r3", dut.Reg[3], 32'd0);
        checkOutput("br_r4", dut.Reg[4], 32'd9);
        checkOutput("br_pulses", pulses, 32'd1);
        checkOutput("br_pulse_edge", pulseEdge, 32'd3);
        checkOutput("br_pc", dut.PC, 32'd6);

        clearRegs();
        prog = '{encI(OP_ADDI, 5'd0, 5'd1, 16'hffff), encI(OP_SLTI, 5'd1, 5'd2, 16'd0),
                 encR(OP_MUL, 5'd1, 5'd1, 5'd3), encI(OP_ADDI, 5'd0, 5'd0, 16'd5), HLT_W};
        applyStimulus(30);
        checkOutput("edge_r1", dut.Reg[1], 32'hffff_ffff);
        checkOutput("edge_r2", dut.Reg[2], 32'd1);
        checkOutput("edge_r3", dut.Reg[3], 32'd1);
        checkOutput("edge_r0", dut.Reg[0], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
